// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: shared constants for the Common Data Bus arbiter.
//   - Requester count and winner index width.
//   - Fixed source indices (ALU, BranchALU, LSBuffer) as they appear on cdb_src.
//   - Default tag/data widths and the idle tag value.
package cdb_arbiter_pkg;

  localparam int CDB_REQ_NUM   = 3;
  localparam int CDB_SRC_W     = 2;

  localparam int CDB_SRC_ALU    = 0;
  localparam int CDB_SRC_BRANCH = 1;
  localparam int CDB_SRC_LS     = 2;

  localparam int TAG_WIDTH  = 5;
  localparam int DATA_WIDTH = 32;

  // ROB tags run 0..30. All-ones is reserved to mean "no tag on the bus".
  localparam logic [TAG_WIDTH-1:0] TAG_FREE = '1;

  typedef enum logic [CDB_SRC_W-1:0] {
    SRC_ALU    = 2'd0,
    SRC_BRANCH = 2'd1,
    SRC_LS     = 2'd2
  } cdb_src_e;

endpackage

// File: rtl/cdb_rr_pick.sv
// cdb_rr_pick: combinational round-robin priority picker.
//   req       in   NUM_REQ  occupied-slot vector
//   rr_ptr    in   SRC_W    highest-priority index this cycle (< NUM_REQ)
//   grant     out  NUM_REQ  one-hot grant, zero when nothing requested
//   winner    out  SRC_W    index of the granted requester (0 when none)
//   any_grant out  1        some requester was granted
module cdb_rr_pick
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = CDB_REQ_NUM,
  parameter int SRC_W   = CDB_SRC_W
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [SRC_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [SRC_W-1:0]   winner,
  output logic               any_grant
);

  // One extra bit so rr_ptr + k cannot overflow before the modulo fold.
  localparam logic [SRC_W:0] NREQ = (SRC_W+1)'(NUM_REQ);

  logic [SRC_W:0] pos;

  always_comb begin
    grant     = '0;
    winner    = '0;
    any_grant = 1'b0;
    pos       = '0;
    // Walk rr_ptr, rr_ptr+1, ... with wrap; first occupied slot wins.
    // rr_ptr < NUM_REQ, so a single subtraction is a full modulo.
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = {1'b0, rr_ptr} + (SRC_W+1)'(k);
      if (pos >= NREQ) pos = pos - NREQ;
      if (!any_grant && req[pos[SRC_W-1:0]]) begin
        grant[pos[SRC_W-1:0]] = 1'b1;
        winner                = pos[SRC_W-1:0];
        any_grant             = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares the Common Data Bus among ALU, BranchALU and LSBuffer.
// Each producer hands one tag/data result into a private one-entry slot via
// valid/ready; a round-robin picker drains one slot per cycle onto the
// registered broadcast consumed by the ROB and reservation stations.
//   clk        in   1               clock
//   rst        in   1               synchronous active-high reset
//   flush      in   1               mispredict flush, drops pending results
//   req_valid  in   NUM_REQ         per-requester result valid
//   req_tag    in   NUM_REQ*TAG_W   packed tags, requester i at [i*TAG_W +: TAG_W]
//   req_data   in   NUM_REQ*DATA_W  packed results, same packing
//   req_ready  out  NUM_REQ         slot i accepts this cycle
//   cdb_valid  out  1               broadcast valid (one-cycle pulse per result)
//   cdb_tag    out  TAG_W           broadcast tag, TAG_IDLE when idle
//   cdb_data   out  DATA_W          broadcast data, 0 when idle
//   cdb_src    out  SRC_W           broadcasting requester, 0 when idle
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int               NUM_REQ  = CDB_REQ_NUM,
  parameter int               TAG_W    = TAG_WIDTH,
  parameter int               DATA_W   = DATA_WIDTH,
  parameter int               SRC_W    = CDB_SRC_W,
  parameter logic [TAG_W-1:0] TAG_IDLE = TAG_W'(TAG_FREE)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*TAG_W-1:0]    req_tag,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        cdb_valid,
  output logic [TAG_W-1:0]            cdb_tag,
  output logic [DATA_W-1:0]           cdb_data,
  output logic [SRC_W-1:0]            cdb_src
);

  localparam logic [SRC_W-1:0] LAST = SRC_W'(NUM_REQ-1);

  logic [NUM_REQ-1:0]             slot_valid;
  logic [NUM_REQ-1:0][TAG_W-1:0]  slot_tag;
  logic [NUM_REQ-1:0][DATA_W-1:0] slot_data;
  logic [SRC_W-1:0]               rr_ptr;

  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] cap;
  logic [SRC_W-1:0]   winner;
  logic [SRC_W-1:0]   ptr_next;
  logic               any_grant;

  // Picker sees registered state only, so nothing on req_* reaches req_ready.
  cdb_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .SRC_W   (SRC_W)
  ) u_pick (
    .req       (slot_valid),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .winner    (winner),
    .any_grant (any_grant)
  );

  // A slot draining this cycle may be refilled on the same edge.
  assign req_ready = {NUM_REQ{~flush}} & (~slot_valid | grant);
  assign cap       = req_valid & req_ready;

  // Explicit wrap: NUM_REQ need not be a power of two.
  assign ptr_next = (winner == LAST) ? '0 : winner + 1'b1;

  // Payload registers need no reset; slot_valid qualifies them.
  // cap is already zero during flush because req_ready is.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (cap[i]) begin
        slot_tag[i]  <= req_tag[i*TAG_W +: TAG_W];
        slot_data[i] <= req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_valid <= '0;
      rr_ptr     <= '0;
      cdb_valid  <= 1'b0;
      cdb_tag    <= TAG_IDLE;
      cdb_data   <= '0;
      cdb_src    <= '0;
    end else if (flush) begin
      // rr_ptr holds so fairness survives a mispredict.
      slot_valid <= '0;
      cdb_valid  <= 1'b0;
      cdb_tag    <= TAG_IDLE;
      cdb_data   <= '0;
      cdb_src    <= '0;
    end else begin
      slot_valid <= (slot_valid & ~grant) | cap;
      if (any_grant) begin
        cdb_valid <= 1'b1;
        cdb_tag   <= slot_tag[winner];
        cdb_data  <= slot_data[winner];
        cdb_src   <= winner;
        rr_ptr    <= ptr_next;
      end else begin
        cdb_valid <= 1'b0;
        cdb_tag   <= TAG_IDLE;
        cdb_data  <= '0;
        cdb_src   <= '0;
      end
    end
  end

  a_grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
  a_ptr_range:    assert property (@(posedge clk) disable iff (rst) rr_ptr <= LAST);

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;

  localparam logic [4:0] TF = 5'h1F;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [2:0]  req_valid = '0;
  logic [14:0] req_tag = '0;
  logic [95:0] req_data = '0;
  logic [2:0]  req_ready;
  logic        cdb_valid;
  logic [4:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic [1:0]  cdb_src;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cdb_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .req_valid (req_valid),
    .req_tag   (req_tag),
    .req_data  (req_data),
    .req_ready (req_ready),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data),
    .cdb_src   (cdb_src)
  );

  // One record per cycle: inputs driven before the edge, req_ready expected
  // before the edge (when ck set), cdb_* expected after the edge.
  typedef struct {
    logic        rst, fl;
    logic [2:0]  v;
    logic [4:0]  t0, t1, t2;
    logic [31:0] d0, d1, d2;
    logic        ck;
    logic [2:0]  rdy;
    logic        cv;
    logic [4:0]  ct;
    logic [31:0] cd;
    logic [1:0]  cs;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int r, int f, int v, int t0, int d0, int t1, int d1,
                              int t2, int d2, int ck, int rdy, int cv, int ct, int cd, int cs);
    vec_t x;
    x.rst = 1'(r);  x.fl = 1'(f);  x.v = 3'(v);
    x.t0 = 5'(t0);  x.t1 = 5'(t1); x.t2 = 5'(t2);
    x.d0 = 32'(d0); x.d1 = 32'(d1); x.d2 = 32'(d2);
    x.ck = 1'(ck);  x.rdy = 3'(rdy);
    x.cv = 1'(cv);  x.ct = 5'(ct); x.cd = 32'(cd); x.cs = 2'(cs);
    return x;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL v%0d %s: got %0h expected %0h", idx, nm, act, exp);
    end
  endtask

  initial begin
    // reset held two cycles with all requesters valid
    tbl.push_back(mk(1,0,3'b111, 1,'h11, 2,'h22, 3,'h33, 0,3'b000, 0,TF,0,0));
    tbl.push_back(mk(1,0,3'b111, 1,'h11, 2,'h22, 3,'h33, 1,3'b111, 0,TF,0,0));
    tbl.push_back(mk(0,0,3'b000, 0,0, 0,0, 0,0,          1,3'b111, 0,TF,0,0));
    // single requester, then back-to-back
    tbl.push_back(mk(0,0,3'b001, 5,'h1234, 0,0, 0,0,     1,3'b111, 0,TF,0,0));
    tbl.push_back(mk(0,0,3'b001, 6,'h66, 0,0, 0,0,       1,3'b111, 1,5,'h1234,0));
    tbl.push_back(mk(0,0,3'b001, 7,'h77, 0,0, 0,0,       1,3'b111, 1,6,'h66,0));
    tbl.push_back(mk(0,0,3'b000, 0,0, 0,0, 0,0,          1,3'b111, 1,7,'h77,0));
    tbl.push_back(mk(0,0,3'b000, 0,0, 0,0, 0,0,          1,3'b111, 0,TF,0,0));
    // reset again so rr_ptr=0, then full contention
    tbl.push_back(mk(1,0,3'b000, 0,0, 0,0, 0,0,          1,3'b111, 0,TF,0,0));
    tbl.push_back(mk(0,0,3'b111, 1,'h11, 2,'h22, 3,'h33, 1,3'b111, 0,TF,0,0));
    tbl.push_back(mk(0,0,3'b000, 0,0, 0,0, 0,0,          1,3'b001, 1,1,'h11,0));
    tbl.push_back(mk(0,0,3'b000, 0,0, 0,0, 0,0,          1,3'b011, 1,2,'h22,1));
    tbl.push_back(mk(0,0,3'b000, 0,0, 0,0, 0,0,          1,3'b111, 1,3,'h33,2));
    tbl.push_back(mk(0,0,3'b000, 0,0, 0,0, 0,0,          1,3'b111, 0,TF,0,0));
    // fairness: ALU and LSBuffer always valid, each holds until accepted
    tbl.push_back(mk(0,0,3'b101, 10,'hA10, 0,0, 20,'hC20, 1,3'b111, 0,TF,0,0));
    tbl.push_back(mk(0,0,3'b101, 11,'hA11, 0,0, 21,'hC21, 1,3'b011, 1,10,'hA10,0));
    tbl.push_back(mk(0,0,3'b101, 12,'hA12, 0,0, 21,'hC21, 1,3'b110, 1,20,'hC20,2));
    tbl.push_back(mk(0,0,3'b101, 12,'hA12, 0,0, 22,'hC22, 1,3'b011, 1,11,'hA11,0));
    tbl.push_back(mk(0,0,3'b101, 13,'hA13, 0,0, 22,'hC22, 1,3'b110, 1,21,'hC21,2));
    tbl.push_back(mk(0,0,3'b101, 13,'hA13, 0,0, 23,'hC23, 1,3'b011, 1,12,'hA12,0));
    tbl.push_back(mk(0,0,3'b100, 0,0, 0,0, 23,'hC23,     1,3'b110, 1,22,'hC22,2));
    tbl.push_back(mk(0,0,3'b000, 0,0, 0,0, 0,0,          1,3'b011, 1,13,'hA13,0));
    tbl.push_back(mk(0,0,3'b000, 0,0, 0,0, 0,0,          1,3'b111, 1,23,'hC23,2));
    tbl.push_back(mk(0,0,3'b000, 0,0, 0,0, 0,0,          1,3'b111, 0,TF,0,0));
    // flush: BranchALU tag 4 and LSBuffer tag 9 pending, never broadcast;
    // ALU offered during flush is not captured
    tbl.push_back(mk(0,0,3'b110, 0,0, 4,'h444, 9,'h999,  1,3'b111, 0,TF,0,0));
    tbl.push_back(mk(0,1,3'b001, 30,'h300, 0,0, 0,0,     1,3'b000, 0,TF,0,0));
    tbl.push_back(mk(0,0,3'b000, 0,0, 0,0, 0,0,          1,3'b111, 0,TF,0,0));
    tbl.push_back(mk(0,0,3'b000, 0,0, 0,0, 0,0,          1,3'b111, 0,TF,0,0));
    // reset mid-operation with two slots full and a broadcast on the bus
    tbl.push_back(mk(0,0,3'b011, 14,'hE14, 15,'hF15, 0,0, 1,3'b111, 0,TF,0,0));
    tbl.push_back(mk(0,0,3'b001, 16,'hE16, 0,0, 0,0,     1,3'b101, 1,14,'hE14,0));
    tbl.push_back(mk(1,0,3'b000, 0,0, 0,0, 0,0,          1,3'b110, 0,TF,0,0));
    tbl.push_back(mk(0,0,3'b000, 0,0, 0,0, 0,0,          1,3'b111, 0,TF,0,0));
    tbl.push_back(mk(0,0,3'b111, 17,'h170, 18,'h180, 19,'h190, 1,3'b111, 0,TF,0,0));
    tbl.push_back(mk(0,0,3'b000, 0,0, 0,0, 0,0,          1,3'b001, 1,17,'h170,0));
    tbl.push_back(mk(0,0,3'b000, 0,0, 0,0, 0,0,          1,3'b011, 1,18,'h180,1));
    tbl.push_back(mk(0,0,3'b000, 0,0, 0,0, 0,0,          1,3'b111, 1,19,'h190,2));
    tbl.push_back(mk(0,0,3'b000, 0,0, 0,0, 0,0,          1,3'b111, 0,TF,0,0));

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst       = tbl[i].rst;
      flush     = tbl[i].fl;
      req_valid = tbl[i].v;
      req_tag   = {tbl[i].t2, tbl[i].t1, tbl[i].t0};
      req_data  = {tbl[i].d2, tbl[i].d1, tbl[i].d0};
      #1;
      if (tbl[i].ck) chk("req_ready", i, 32'(req_ready), 32'(tbl[i].rdy));
      @(posedge clk);
      #1;
      chk("cdb_valid", i, 32'(cdb_valid), 32'(tbl[i].cv));
      chk("cdb_tag",   i, 32'(cdb_tag),   32'(tbl[i].ct));
      chk("cdb_data",  i, cdb_data,       tbl[i].cd);
      chk("cdb_src",   i, 32'(cdb_src),   32'(tbl[i].cs));
    end

    // Simultaneous rst and flush: rst wins, so rr_ptr is cleared (flush alone
    // would hold it). Leave rr_ptr at 1 first, then check the grant order.
    @(negedge clk);
    req_valid = 3'b001; req_tag = {5'd0, 5'd0, 5'd24}; req_data = {32'h0, 32'h0, 32'h240};
    @(negedge clk);
    req_valid = 3'b000;
    @(posedge clk); #1;
    chk("seq_pre_src", 100, 32'(cdb_src), 32'd0);
    chk("seq_pre_tag", 100, 32'(cdb_tag), 32'd24);
    @(negedge clk);
    rst = 1'b1; flush = 1'b1;
    #1;
    chk("seq_ready_flush", 101, 32'(req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0; flush = 1'b0;
    req_valid = 3'b110; req_tag = {5'd26, 5'd25, 5'd0}; req_data = {32'h260, 32'h250, 32'h0};
    @(negedge clk);
    req_valid = 3'b000;
    #1;
    chk("seq_ready_wait", 102, 32'(req_ready), 32'b011);
    @(posedge clk); #1;
    // rr_ptr=0 after reset: search 0,1 -> BranchALU first, then LSBuffer
    chk("seq_first_src", 103, 32'(cdb_src), 32'd1);
    chk("seq_first_tag", 103, 32'(cdb_tag), 32'd25);
    @(posedge clk); #1;
    chk("seq_second_src", 104, 32'(cdb_src), 32'd2);
    chk("seq_second_data", 104, cdb_data, 32'h260);
    @(posedge clk); #1;
    chk("seq_idle_valid", 105, 32'(cdb_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
